wm_power_arbiter: RTL and testbench

Shared mains-power arbiter for the washing-machine actuators. The cycle controller raises per-actuator requests (drain pump, water valve, detergent valve, drum motor, heater), and this block grants them against a fixed current budget. It staggers switch-on events to limit inrush, and it pre-empts heavy loads so the drain pump is never starved. It sits between the cycle FSM's actuator outputs and the physical drivers; actuator pins are driven by `req & grant`.

---
 rtl/wm_pkg.sv | 26 ++
 rtl/wm_pwr_pick.sv | 52 +++++
 rtl/wm_power_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_wm_power_arbiter.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/wm_pkg.sv
// Shared definitions for the washing-machine power arbiter:
// requester indices, FSM state encoding and the default load table.
package wm_pkg;

    localparam int NUM_REQ    = 5;
    localparam int REQ_DRAIN  = 0;
    localparam int REQ_VALVE  = 1;
    localparam int REQ_DET    = 2;
    localparam int REQ_MOTOR  = 3;
    localparam int REQ_HEATER = 4;

    // Arbiter FSM state encoding
    typedef logic [1:0] state_t;
    localparam state_t ST_READY   = 2'd0;
    localparam state_t ST_HOLDOFF = 2'd1;
    localparam state_t ST_PREEMPT = 2'd2;

    // Default budget and per-requester load units
    localparam int DEF_BUDGET      = 12;
    localparam int DEF_LOAD_DRAIN  = 2;
    localparam int DEF_LOAD_VALVE  = 1;
    localparam int DEF_LOAD_DET    = 1;
    localparam int DEF_LOAD_MOTOR  = 6;
    localparam int DEF_LOAD_HEATER = 8;

endpackage

// File: rtl/wm_pwr_pick.sv
// Combinational candidate selection: a requester is a candidate when it
// is requested, not yet granted and fits in the remaining budget. Valves
// and drain use fixed priority; motor and heater share a round-robin slot.
// Returns a one-hot pick (all zero when nothing qualifies).
module wm_pwr_pick
    import wm_pkg::*;
#(
    parameter int BUDGET      = DEF_BUDGET,
    parameter int LOAD_DRAIN  = DEF_LOAD_DRAIN,
    parameter int LOAD_VALVE  = DEF_LOAD_VALVE,
    parameter int LOAD_DET    = DEF_LOAD_DET,
    parameter int LOAD_MOTOR  = DEF_LOAD_MOTOR,
    parameter int LOAD_HEATER = DEF_LOAD_HEATER
) (
    input  logic [4:0] req,
    input  logic [4:0] grant,
    input  logic [5:0] load_base,
    input  logic       rr_heater,
    output logic [4:0] pick
);

    logic [4:0] fit;
    logic [4:0] cand;

    // Fit check against the budget left after this cycle's releases
    always_comb begin
        fit             = '0;
        fit[REQ_DRAIN]  = ({1'b0, load_base} + 7'(LOAD_DRAIN))  <= 7'(BUDGET);
        fit[REQ_VALVE]  = ({1'b0, load_base} + 7'(LOAD_VALVE))  <= 7'(BUDGET);
        fit[REQ_DET]    = ({1'b0, load_base} + 7'(LOAD_DET))    <= 7'(BUDGET);
        fit[REQ_MOTOR]  = ({1'b0, load_base} + 7'(LOAD_MOTOR))  <= 7'(BUDGET);
        fit[REQ_HEATER] = ({1'b0, load_base} + 7'(LOAD_HEATER)) <= 7'(BUDGET);
    end

    assign cand = req & ~grant & fit;

    // Fixed priority drain > valve > detergent, then motor/heater by pointer
    always_comb begin
        pick = '0;
        if (cand[REQ_DRAIN])
            pick[REQ_DRAIN] = 1'b1;
        else if (cand[REQ_VALVE])
            pick[REQ_VALVE] = 1'b1;
        else if (cand[REQ_DET])
            pick[REQ_DET] = 1'b1;
        else if (cand[REQ_MOTOR] && (!rr_heater || !cand[REQ_HEATER]))
            pick[REQ_MOTOR] = 1'b1;
        else if (cand[REQ_HEATER])
            pick[REQ_HEATER] = 1'b1;
    end

endmodule

// File: rtl/wm_power_arbiter.sv
// Mains-power arbiter for the washing-machine actuators. Grants requests
// against a fixed load budget, admits at most one new load per STAGGER
// cycles, and pre-empts heater/motor (after MIN_ON) so drain can run.
// Optional feature macro: WM_PWR_STARVE_EN adds per-requester denial
// counters and the sticky starve output.
module wm_power_arbiter
    import wm_pkg::*;
#(
    parameter int BUDGET      = DEF_BUDGET,
    parameter int LOAD_DRAIN  = DEF_LOAD_DRAIN,
    parameter int LOAD_VALVE  = DEF_LOAD_VALVE,
    parameter int LOAD_DET    = DEF_LOAD_DET,
    parameter int LOAD_MOTOR  = DEF_LOAD_MOTOR,
    parameter int LOAD_HEATER = DEF_LOAD_HEATER,
    parameter int STAGGER     = 4,
    parameter int MIN_ON      = 8,
    parameter int STARVE      = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [4:0] req,
    output logic [4:0] grant,
    output logic [5:0] load_used,
    output logic [4:0] denied
`ifdef WM_PWR_STARVE_EN
    ,
    output logic [4:0] starve
`endif
);

    // Drain can only be helped by pre-emption if it fits an empty budget
    localparam bit DRAIN_OK = (LOAD_DRAIN <= BUDGET);

    state_t     state, state_nx;
    logic [3:0] stag_cnt, stag_nx;
    logic       rr_heater;
    logic [7:0] on_motor, on_heater;

    logic [4:0] kept, pick, revoke, grant_nx;
    logic [5:0] load_kept;
    logic       admit, drain_fits, need_pre;
    logic       motor_exp, heater_exp;

    function automatic logic [5:0] load_sum(input logic [4:0] g);
        load_sum = (g[REQ_DRAIN]  ? 6'(LOAD_DRAIN)  : 6'd0)
                 + (g[REQ_VALVE]  ? 6'(LOAD_VALVE)  : 6'd0)
                 + (g[REQ_DET]    ? 6'(LOAD_DET)    : 6'd0)
                 + (g[REQ_MOTOR]  ? 6'(LOAD_MOTOR)  : 6'd0)
                 + (g[REQ_HEATER] ? 6'(LOAD_HEATER) : 6'd0);
    endfunction

    // Hold counter step: load on a new grant, count down while held, else 0
    function automatic logic [7:0] next_on(input logic nx, input logic cur,
                                           input logic [7:0] cnt);
        if (!nx)
            next_on = '0;
        else if (!cur)
            next_on = 8'(MIN_ON);
        else
            next_on = (cnt != 8'd0) ? cnt - 8'd1 : 8'd0;
    endfunction

    // Releases take effect this edge, so admission sees the reduced load
    assign kept       = grant & req;
    assign load_kept  = load_sum(kept);
    assign drain_fits = ({1'b0, load_kept} + 7'(LOAD_DRAIN)) <= 7'(BUDGET);
    assign need_pre   = req[REQ_DRAIN] & ~grant[REQ_DRAIN] & DRAIN_OK & ~drain_fits;
    // A count of 1 reaches 0 on this edge: MIN_ON full cycles have been held
    assign motor_exp  = on_motor  <= 8'd1;
    assign heater_exp = on_heater <= 8'd1;

    wm_pwr_pick #(
        .BUDGET      (BUDGET),
        .LOAD_DRAIN  (LOAD_DRAIN),
        .LOAD_VALVE  (LOAD_VALVE),
        .LOAD_DET    (LOAD_DET),
        .LOAD_MOTOR  (LOAD_MOTOR),
        .LOAD_HEATER (LOAD_HEATER)
    ) u_pick (
        .req       (req),
        .grant     (grant),
        .load_base (load_kept),
        .rr_heater (rr_heater),
        .pick      (pick)
    );

    // Next-state: admission, stagger holdoff and drain pre-emption
    always_comb begin
        state_nx = state;
        stag_nx  = stag_cnt;
        revoke   = '0;
        admit    = 1'b0;
        case (state)
            ST_READY: begin
                if (need_pre) begin
                    state_nx = ST_PREEMPT;
                end else if (|pick) begin
                    admit    = 1'b1;
                    state_nx = ST_HOLDOFF;
                    stag_nx  = 4'(STAGGER - 1);
                end
            end
            ST_HOLDOFF: begin
                if (need_pre) begin
                    state_nx = ST_PREEMPT;
                    stag_nx  = '0;
                end else if (stag_cnt <= 4'd1) begin
                    state_nx = ST_READY;
                    stag_nx  = '0;
                end else begin
                    stag_nx  = stag_cnt - 4'd1;
                end
            end
            ST_PREEMPT: begin
                // Drain fits (or went away): back to READY, admit next edge
                if (!need_pre) begin
                    state_nx = ST_READY;
                    stag_nx  = '0;
                end else if (kept[REQ_HEATER] && heater_exp) begin
                    revoke[REQ_HEATER] = 1'b1;
                end else if (kept[REQ_MOTOR] && motor_exp) begin
                    revoke[REQ_MOTOR] = 1'b1;
                end
            end
            default: begin
                state_nx = ST_READY;
                stag_nx  = '0;
            end
        endcase
        grant_nx = (kept & ~revoke) | (admit ? pick : 5'd0);
        if (!enable) begin
            grant_nx = '0;
            state_nx = ST_READY;
            stag_nx  = '0;
        end
    end

    // Registered grant, load and FSM state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_READY;
            stag_cnt  <= '0;
            grant     <= '0;
            load_used <= '0;
            denied    <= '0;
        end else begin
            state     <= state_nx;
            stag_cnt  <= stag_nx;
            grant     <= grant_nx;
            load_used <= load_sum(grant_nx);
            denied    <= enable ? (req & ~grant_nx) : 5'd0;
        end
    end

    // Round-robin pointer points away from whichever heavy load won last
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            rr_heater <= 1'b0;
        else if (admit && pick[REQ_MOTOR])
            rr_heater <= 1'b1;
        else if (admit && pick[REQ_HEATER])
            rr_heater <= 1'b0;
    end

    // MIN_ON hold counters for motor and heater
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            on_motor  <= '0;
            on_heater <= '0;
        end else begin
            on_motor  <= next_on(grant_nx[REQ_MOTOR],  grant[REQ_MOTOR],  on_motor);
            on_heater <= next_on(grant_nx[REQ_HEATER], grant[REQ_HEATER], on_heater);
        end
    end

`ifdef WM_PWR_STARVE_EN
    logic [4:0][7:0] dcnt, dcnt_nx;

    // Denial counters: count denied cycles, restart on a new grant
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            dcnt_nx[i] = dcnt[i];
            if (!enable || (grant_nx[i] && !grant[i]))
                dcnt_nx[i] = '0;
            else if (denied[i] && dcnt[i] != 8'hFF)
                dcnt_nx[i] = dcnt[i] + 8'd1;
        end
    end

    // Starve flags are sticky until reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dcnt   <= '0;
            starve <= '0;
        end else begin
            dcnt <= dcnt_nx;
            for (int i = 0; i < NUM_REQ; i++)
                if (dcnt_nx[i] >= 8'(STARVE))
                    starve[i] <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_wm_power_arbiter.sv
// Directed bench for wm_power_arbiter: a vector table for the main
// admission/stagger/enable flow, plus hand sequences for round-robin,
// drain pre-emption, reset during pre-emption and an over-budget load.
module tb_wm_power_arbiter;

    logic       clk = 1'b0;
    logic       reset_a, reset_b, reset_c;
    logic       enable_a, enable_b, enable_c;
    logic [4:0] req_a, req_b, req_c;
    logic [4:0] grant_a, grant_b, grant_c;
    logic [5:0] load_a, load_b, load_c;
    logic [4:0] denied_a, denied_b, denied_c;
`ifdef WM_PWR_STARVE_EN
    logic [4:0] starve_a, starve_b, starve_c;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    // Default configuration
    wm_power_arbiter u_a (
        .clk(clk), .reset(reset_a), .enable(enable_a), .req(req_a),
        .grant(grant_a), .load_used(load_a), .denied(denied_a)
`ifdef WM_PWR_STARVE_EN
        , .starve(starve_a)
`endif
    );

    // Reduced budget for the pre-emption scenario
    wm_power_arbiter #(.BUDGET(10)) u_b (
        .clk(clk), .reset(reset_b), .enable(enable_b), .req(req_b),
        .grant(grant_b), .load_used(load_b), .denied(denied_b)
`ifdef WM_PWR_STARVE_EN
        , .starve(starve_b)
`endif
    );

    // Heater load larger than the budget
    wm_power_arbiter #(.LOAD_HEATER(13)) u_c (
        .clk(clk), .reset(reset_c), .enable(enable_c), .req(req_c),
        .grant(grant_c), .load_used(load_c), .denied(denied_c)
`ifdef WM_PWR_STARVE_EN
        , .starve(starve_c)
`endif
    );

    typedef struct {
        logic [4:0] req;
        logic       en;
        int         ncyc;
        logic [4:0] grant;
        logic [5:0] load;
        logic [4:0] denied;
    } vec_t;

    vec_t tbl [12];

    task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        // edge numbers in comments count from reset release
        tbl[0]  = '{5'b11111, 1'b1, 1, 5'b00001,  6'd2, 5'b11110}; // e1 drain
        tbl[1]  = '{5'b11111, 1'b1, 3, 5'b00001,  6'd2, 5'b11110}; // e4 still staggered
        tbl[2]  = '{5'b11111, 1'b1, 1, 5'b00011,  6'd3, 5'b11100}; // e5 valve
        tbl[3]  = '{5'b11111, 1'b1, 4, 5'b00111,  6'd4, 5'b11000}; // e9 detergent
        tbl[4]  = '{5'b11111, 1'b1, 4, 5'b01111, 6'd10, 5'b10000}; // e13 motor
        tbl[5]  = '{5'b11111, 1'b1, 8, 5'b01111, 6'd10, 5'b10000}; // e21 heater never fits
        tbl[6]  = '{5'b10111, 1'b1, 1, 5'b10111, 6'd12, 5'b00000}; // e22 motor out, heater in
        tbl[7]  = '{5'b11111, 1'b1, 1, 5'b10111, 6'd12, 5'b01000}; // e23 holdoff
        tbl[8]  = '{5'b11111, 1'b0, 1, 5'b00000,  6'd0, 5'b00000}; // e24 disable
        tbl[9]  = '{5'b11111, 1'b1, 1, 5'b00001,  6'd2, 5'b11110}; // e25 restart
        tbl[10] = '{5'b11111, 1'b1, 4, 5'b00011,  6'd3, 5'b11100}; // e29 next after 4
        tbl[11] = '{5'b00000, 1'b1, 1, 5'b00000,  6'd0, 5'b00000}; // e30 release all

        reset_a = 1'b1; reset_b = 1'b1; reset_c = 1'b1;
        enable_a = 1'b1; enable_b = 1'b1; enable_c = 1'b1;
        req_a = '0; req_b = '0; req_c = '0;
        #2;
        check("reset grant",  6'(grant_a),  6'd0);
        check("reset load",   load_a,       6'd0);
        check("reset denied", 6'(denied_a), 6'd0);
`ifdef WM_PWR_STARVE_EN
        check("reset starve", 6'(starve_a), 6'd0);
`endif
        @(negedge clk);
        reset_a = 1'b0; reset_b = 1'b0; reset_c = 1'b0;

        // Table-driven main flow on the default instance
        for (int i = 0; i < 12; i++) begin
            req_a    = tbl[i].req;
            enable_a = tbl[i].en;
            step(tbl[i].ncyc);
            check($sformatf("vec%0d grant", i),  6'(grant_a),  6'(tbl[i].grant));
            check($sformatf("vec%0d load", i),   load_a,       tbl[i].load);
            check($sformatf("vec%0d denied", i), 6'(denied_a), 6'(tbl[i].denied));
        end

        // Round-robin between motor and heater (heater won last)
        step(5);
        for (int k = 0; k < 3; k++) begin
            req_a = 5'b11000;
            step(1);
            check($sformatf("rr%0d grant", k), 6'(grant_a), (k == 1) ? 6'b010000 : 6'b001000);
            check($sformatf("rr%0d load", k),  load_a,      (k == 1) ? 6'd8 : 6'd6);
            req_a = 5'b00000;
            step(5);
            check($sformatf("rr%0d idle", k),  6'(grant_a), 6'd0);
        end

        // Drain pre-empts heater once MIN_ON has elapsed (budget 10)
        req_b = 5'b10110;
        step(9);
        check("pre e9 grant", 6'(grant_b), 6'b010110);
        check("pre e9 load",  load_b,      6'd10);
        step(2);
        req_b = 5'b10111;
        step(5);
        check("pre e16 grant",  6'(grant_b),  6'b010110);
        check("pre e16 denied", 6'(denied_b), 6'b000001);
        step(1);
        check("pre e17 grant", 6'(grant_b), 6'b000110);
        check("pre e17 load",  load_b,      6'd2);
        step(1);
        check("pre e18 grant", 6'(grant_b), 6'b000110);
        step(1);
        check("pre e19 grant",  6'(grant_b),  6'b000111);
        check("pre e19 load",   load_b,       6'd4);
        check("pre e19 denied", 6'(denied_b), 6'b010000);

        // Reset asserted while in PREEMPT clears outputs without a clock
        req_b = 5'b00000;
        #1 reset_b = 1'b1;
        @(negedge clk);
        reset_b = 1'b0;
        req_b = 5'b10110;
        step(11);
        req_b = 5'b10111;
        step(2);
        #1 reset_b = 1'b1;
        #1;
        check("async grant",  6'(grant_b),  6'd0);
        check("async load",   load_b,       6'd0);
        check("async denied", 6'(denied_b), 6'd0);
        @(negedge clk);
        reset_b = 1'b0;
        req_b = 5'b00010;
        step(1);
        check("after reset grant", 6'(grant_b), 6'b000010);
        check("after reset load",  load_b,      6'd1);

        // Heater load above budget is never granted
        req_c = 5'b10000;
        step(3);
        check("big grant",  6'(grant_c),  6'd0);
        check("big load",   load_c,       6'd0);
        check("big denied", 6'(denied_c), 6'b010000);
        step(61);
        check("big e64 grant",  6'(grant_c),  6'd0);
        check("big e64 denied", 6'(denied_c), 6'b010000);
`ifdef WM_PWR_STARVE_EN
        check("starve e64", 6'(starve_c), 6'd0);
        step(1);
        check("starve e65", 6'(starve_c), 6'b010000);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
